// File: rtl/rv_ctrl_pkg.sv
// rv_ctrl_pkg: RV32I opcodes, issue FSM states and default limits shared by issue_ctrl
package rv_ctrl_pkg;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  typedef enum logic [1:0] {RUN, FLUSH, MEMWAIT, ERR} issue_state_t;
  localparam int FLUSH_CYCLES_DEF = 2;
  localparam int MEM_TIMEOUT_DEF  = 255;
  localparam int TO_W_DEF         = 8;
endpackage

// File: rtl/reg_use_dec.sv
// reg_use_dec: tells which source registers an ID-stage opcode actually reads
// opcode in; use_rs1/use_rs2 out (unknown opcodes read nothing)
module reg_use_dec
  import rv_ctrl_pkg::*;
(
  input  logic [6:0] opcode,
  output logic       use_rs1,
  output logic       use_rs2
);
  assign use_rs1 = opcode inside {OPC_JALR, OPC_BRANCH, OPC_LOAD, OPC_STORE, OPC_OP_IMM, OPC_OP};
  assign use_rs2 = opcode inside {OPC_BRANCH, OPC_STORE, OPC_OP};
endmodule

// File: rtl/issue_ctrl.sv
// issue_ctrl: fetch/decode issue and hazard control (load-use bubbles, branch flush, dmem freeze, timeout)
// in : clk, rst (async, high), if_valid, id_opcode/id_rs1/id_rs2, ex_is_load/ex_rd, br_taken, dmem_req/dmem_ack
// out: cu_en (0 = bubble), if_ready, pc_stall, pipe_stall, flush_id, flush_ex, mem_err (sticky)
// ISSUE_CTRL_PERF_EN adds perf_stall, perf_bubble, perf_flush 32-bit event counters
module issue_ctrl
  import rv_ctrl_pkg::*;
#(
  parameter int FLUSH_CYCLES = FLUSH_CYCLES_DEF,
  parameter int MEM_TIMEOUT  = MEM_TIMEOUT_DEF,
  parameter int TO_W         = TO_W_DEF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        if_valid,
  input  logic [6:0]  id_opcode,
  input  logic [4:0]  id_rs1,
  input  logic [4:0]  id_rs2,
  input  logic        ex_is_load,
  input  logic [4:0]  ex_rd,
  input  logic        br_taken,
  input  logic        dmem_req,
  input  logic        dmem_ack,
  output logic        cu_en,
  output logic        if_ready,
  output logic        pc_stall,
  output logic        pipe_stall,
  output logic        flush_id,
  output logic        flush_ex,
  output logic        mem_err
`ifdef ISSUE_CTRL_PERF_EN
  ,
  output logic [31:0] perf_stall,
  output logic [31:0] perf_bubble,
  output logic [31:0] perf_flush
`endif
);
  localparam int FC_W = $clog2(FLUSH_CYCLES + 1);
  issue_state_t state_q, state_d;
  logic [FC_W-1:0] fcnt_q, fcnt_d;
  logic [TO_W-1:0] tcnt_q, tcnt_d;
  logic use_rs1, use_rs2, mem_wait, load_use;
  logic cu, rdy, pcs, ps, fl, err;
  reg_use_dec u_dec (.opcode(id_opcode), .use_rs1(use_rs1), .use_rs2(use_rs2));
  // the ack cycle itself is still frozen: the access completes at the end of it
  assign mem_wait = (state_q == MEMWAIT) || (state_q != ERR && dmem_req && !dmem_ack);
  assign load_use = ex_is_load && ex_rd != 5'd0 &&
                    ((use_rs1 && ex_rd == id_rs1) || (use_rs2 && ex_rd == id_rs2));
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state_q <= RUN;
      fcnt_q  <= '0;
      tcnt_q  <= '0;
    end else begin
      state_q <= state_d;
      fcnt_q  <= fcnt_d;
      tcnt_q  <= tcnt_d;
    end
  always_comb begin
    state_d = state_q;
    fcnt_d  = fcnt_q;
    tcnt_d  = tcnt_q;
    cu  = if_valid;
    rdy = 1'b1;
    pcs = 1'b0;
    ps  = 1'b0;
    fl  = 1'b0;
    err = 1'b0;
    if (state_q == ERR) begin
      {cu, rdy, pcs, ps, err} = 5'b00111;
    end else if (mem_wait) begin
      {cu, rdy, pcs, ps} = 4'b0011;
      if (state_q != MEMWAIT) begin
        state_d = MEMWAIT;
        tcnt_d  = '0;
      end else if (dmem_ack) begin
        state_d = (fcnt_q != '0) ? FLUSH : RUN;
        tcnt_d  = '0;
      end else begin
        tcnt_d  = tcnt_q + 1'b1;
        state_d = (tcnt_q == TO_W'(MEM_TIMEOUT - 1)) ? ERR : MEMWAIT;
      end
    end else if (br_taken) begin
      cu      = 1'b0;
      fl      = 1'b1;
      fcnt_d  = FC_W'(FLUSH_CYCLES - 1);
      state_d = (FLUSH_CYCLES > 1) ? FLUSH : RUN;
    end else if (state_q == FLUSH) begin
      cu      = 1'b0;
      fcnt_d  = fcnt_q - 1'b1;
      state_d = (fcnt_q == FC_W'(1)) ? RUN : FLUSH;
    end else if (load_use) begin
      {cu, rdy, pcs} = 3'b001;
    end
  end
  assign cu_en      = cu  & ~rst;
  assign if_ready   = rdy & ~rst;
  assign pc_stall   = pcs & ~rst;
  assign pipe_stall = ps  & ~rst;
  assign flush_id   = fl  & ~rst;
  assign flush_ex   = fl  & ~rst;
  assign mem_err    = err & ~rst;
`ifdef ISSUE_CTRL_PERF_EN
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      perf_stall  <= '0;
      perf_bubble <= '0;
      perf_flush  <= '0;
    end else begin
      perf_stall  <= perf_stall + 32'(pc_stall);
      perf_bubble <= perf_bubble + 32'(if_valid & ~cu_en);
      perf_flush  <= perf_flush + 32'(flush_id);
    end
`endif
endmodule

// File: tb/tb_issue_ctrl.sv
// tb_issue_ctrl: directed plus random checks of issue_ctrl against a cycle-level behavioural model
module tb_issue_ctrl;
  import rv_ctrl_pkg::*;
  localparam int FC = 2;
  localparam int MT = 4;
  // output vector order: {cu_en, if_ready, pc_stall, pipe_stall, flush_id, flush_ex, mem_err}
  localparam logic [6:0] N = 7'b1100000;
  localparam logic [6:0] S = 7'b0011000;
  localparam logic [6:0] B = 7'b0100110;
  localparam logic [6:0] F = 7'b0100000;
  localparam logic [6:0] H = 7'b0010000;
  localparam logic [6:0] E = 7'b0011001;
  logic clk = 1'b0, rst = 1'b1;
  logic if_valid, ex_is_load, br_taken, dmem_req, dmem_ack;
  logic [6:0] id_opcode;
  logic [4:0] id_rs1, id_rs2, ex_rd;
  logic cu_en, if_ready, pc_stall, pipe_stall, flush_id, flush_ex, mem_err;
  int checks = 0, errors = 0;
  bit m_err = 1'b0;
  int m_flush = 0, m_wait = -1;
  int p_stall = 0, p_bubble = 0, p_flush = 0;
  logic [6:0] ops [10];
`ifdef ISSUE_CTRL_PERF_EN
  logic [31:0] perf_stall, perf_bubble, perf_flush;
`endif
  always #5 clk = ~clk;
  issue_ctrl #(.FLUSH_CYCLES(FC), .MEM_TIMEOUT(MT), .TO_W(8)) dut (
    .clk(clk), .rst(rst), .if_valid(if_valid), .id_opcode(id_opcode), .id_rs1(id_rs1),
    .id_rs2(id_rs2), .ex_is_load(ex_is_load), .ex_rd(ex_rd), .br_taken(br_taken),
    .dmem_req(dmem_req), .dmem_ack(dmem_ack), .cu_en(cu_en), .if_ready(if_ready),
    .pc_stall(pc_stall), .pipe_stall(pipe_stall), .flush_id(flush_id), .flush_ex(flush_ex),
    .mem_err(mem_err)
`ifdef ISSUE_CTRL_PERF_EN
    , .perf_stall(perf_stall), .perf_bubble(perf_bubble), .perf_flush(perf_flush)
`endif
  );
  function automatic bit reads_rs1(input logic [6:0] op);
    return op == OPC_JALR || op == OPC_BRANCH || op == OPC_LOAD ||
           op == OPC_STORE || op == OPC_OP_IMM || op == OPC_OP;
  endfunction
  function automatic bit reads_rs2(input logic [6:0] op);
    return op == OPC_BRANCH || op == OPC_STORE || op == OPC_OP;
  endfunction
  function automatic logic [6:0] model_out();
    bit waiting, hazard;
    waiting = m_wait >= 0 || (dmem_req && !dmem_ack);
    hazard = ex_is_load && ex_rd != 0 &&
             ((reads_rs1(id_opcode) && ex_rd == id_rs1) || (reads_rs2(id_opcode) && ex_rd == id_rs2));
    if (rst) return 7'b0;
    if (m_err) return E;
    if (waiting) return S;
    if (br_taken) return B;
    if (m_flush > 0) return F;
    if (hazard) return H;
    return {if_valid, 6'b100000};
  endfunction
  task automatic model_reset();
    m_err = 1'b0; m_flush = 0; m_wait = -1;
    p_stall = 0; p_bubble = 0; p_flush = 0;
  endtask
  task automatic idle();
    if_valid = 1'b1; id_opcode = OPC_OP_IMM; id_rs1 = 0; id_rs2 = 0;
    ex_is_load = 1'b0; ex_rd = 0; br_taken = 1'b0; dmem_req = 1'b0; dmem_ack = 1'b0;
  endtask
  task automatic cyc(input string tag, input bit lit = 1'b0, input logic [6:0] e = 7'b0);
    logic [6:0] obs, exp;
    @(negedge clk);
    obs = {cu_en, if_ready, pc_stall, pipe_stall, flush_id, flush_ex, mem_err};
    exp = model_out();
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
    if (lit) begin
      checks++;
      assert (obs === e) else begin
        errors++;
        $error("FAIL %s(directed): observed %b expected %b", tag, obs, e);
      end
    end
    @(posedge clk);
    if (rst) model_reset();
    else begin
      p_stall += int'(exp[4]);
      p_bubble += int'(if_valid && !exp[6]);
      if (m_err) ;
      else if (m_wait >= 0) begin
        if (dmem_ack) m_wait = -1;
        else begin
          m_wait++;
          if (m_wait == MT) m_err = 1'b1;
        end
      end else if (dmem_req && !dmem_ack) m_wait = 0;
      else if (br_taken) begin
        m_flush = FC - 1;
        p_flush++;
      end else if (m_flush > 0) m_flush--;
    end
    #1;
  endtask
  initial begin
    logic [6:0] obs;
    ops = '{OPC_LUI, OPC_AUIPC, OPC_JAL, OPC_JALR, OPC_BRANCH, OPC_LOAD, OPC_STORE,
            OPC_OP_IMM, OPC_OP, 7'b1111111};
    idle();
    br_taken = 1'b1;
    cyc("reset", 1, 7'b0);
    rst = 1'b0; idle();
    cyc("normal", 1, N);
    ex_is_load = 1'b1; ex_rd = 5; id_opcode = OPC_OP; id_rs1 = 5; id_rs2 = 1;
    cyc("loaduse_rs1", 1, H);
    ex_is_load = 1'b0;
    cyc("loaduse_after", 1, N);
    ex_is_load = 1'b1; ex_rd = 0; id_rs1 = 0; id_rs2 = 0;
    cyc("load_x0", 1, N);
    ex_rd = 7; id_opcode = OPC_STORE; id_rs1 = 2; id_rs2 = 7;
    cyc("loaduse_rs2", 1, H);
    id_opcode = OPC_LUI; id_rs1 = 7; id_rs2 = 7;
    cyc("lui_no_use", 1, N);
    idle(); br_taken = 1'b1;
    cyc("br_t", 1, B);
    br_taken = 1'b0;
    cyc("br_t1", 1, F);
    if_valid = 1'b0;
    cyc("br_t2", 1, 7'b0100000);
    idle(); dmem_req = 1'b1;
    cyc("mw_entry", 1, S);
    cyc("mw_1", 1, S);
    cyc("mw_2", 1, S);
    dmem_ack = 1'b1;
    cyc("mw_ack", 1, S);
    idle();
    cyc("mw_done", 1, N);
    dmem_req = 1'b1; dmem_ack = 1'b1;
    cyc("mw_zero", 1, N);
    idle(); dmem_req = 1'b1; br_taken = 1'b1;
    cyc("mwbr_entry", 1, S);
    dmem_ack = 1'b1;
    cyc("mwbr_ack", 1, S);
    dmem_req = 1'b0; dmem_ack = 1'b0;
    cyc("mwbr_flush", 1, B);
    br_taken = 1'b0;
    cyc("mwbr_f1", 1, F);
    cyc("mwbr_run", 1, N);
    br_taken = 1'b1;
    cyc("flmw_br", 1, B);
    br_taken = 1'b0; dmem_req = 1'b1;
    cyc("flmw_entry", 1, S);
    dmem_ack = 1'b1;
    cyc("flmw_ack", 1, S);
    idle();
    cyc("flmw_resume", 1, F);
    cyc("flmw_run", 1, N);
    dmem_req = 1'b1;
    cyc("to_entry", 1, S);
    for (int i = 0; i < MT; i++) cyc("to_wait", 1, S);
    idle();
    cyc("to_err", 1, E);
    br_taken = 1'b1; dmem_req = 1'b1; dmem_ack = 1'b1;
    cyc("to_err_hold", 1, E);
    idle(); rst = 1'b1;
    cyc("to_rst", 1, 7'b0);
    rst = 1'b0;
    cyc("to_after_rst", 1, N);
    dmem_req = 1'b1;
    cyc("arst_entry", 1, S);
    cyc("arst_wait", 1, S);
    @(negedge clk);
    #1 rst = 1'b1;
    #1 obs = {cu_en, if_ready, pc_stall, pipe_stall, flush_id, flush_ex, mem_err};
    checks++;
    assert (obs === 7'b0) else begin
      errors++;
      $error("FAIL arst_immediate: observed %b expected %b", obs, 7'b0);
    end
    model_reset(); idle();
    #1 rst = 1'b0;
    cyc("arst_after", 1, N);
    for (int i = 0; i < 1500; i++) begin
      if_valid = $urandom_range(0, 3) != 0;
      id_opcode = ops[$urandom_range(0, 9)];
      id_rs1 = 5'($urandom_range(0, 3));
      id_rs2 = 5'($urandom_range(0, 3));
      ex_rd = 5'($urandom_range(0, 3));
      ex_is_load = $urandom_range(0, 1) != 0;
      br_taken = $urandom_range(0, 7) == 0;
      dmem_req = $urandom_range(0, 4) == 0;
      dmem_ack = $urandom_range(0, 1) != 0;
      rst = m_err ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 199) == 0);
      cyc("rand");
    end
    rst = 1'b0; idle();
    cyc("final", 1, N);
`ifdef ISSUE_CTRL_PERF_EN
    checks++;
    assert (perf_stall === 32'(p_stall) && perf_bubble === 32'(p_bubble) && perf_flush === 32'(p_flush))
    else begin
      errors++;
      $error("FAIL perf: observed %0d/%0d/%0d expected %0d/%0d/%0d",
             perf_stall, perf_bubble, perf_flush, p_stall, p_bubble, p_flush);
    end
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
